hsv_core_flush_responder: RTL and testbench

- Per-stage flush agent for the responder side of the core flush handshake. The requester side is the global flush FSM, which drives flush_req and ANDs/ORs all stage acks.
- Wraps a small stage FIFO between upstream and downstream valid/ready ports and tracks outstanding side transactions (e.g. memory requests).
- On flush: discards buffered data, blocks new issue, waits for outstanding transactions to retire, then raises flush_ack. Releases flush_ack when flush_req falls.
- Instantiated once per pipeline stage that buffers data or owns in-flight transactions.

---
 rtl/hsv_core_flush_responder.sv | 128 ++++++++++++
 tb/tb_hsv_core_flush_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_flush_responder.sv
// Per-stage responder for the core flush handshake: stage FIFO plus side-transaction tracking.
// A flush discards buffered data, blocks issue, waits for outstanding transactions to retire, then acknowledges.
module hsv_core_flush_responder #(
    parameter int WIDTH           = 32,
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush_req,
    output logic             flush_ack,
    input  logic [WIDTH-1:0] in,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] out,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic             txn_issue,
    input  logic             txn_done,
    output logic             issue_allow,
    output logic [OUT_W-1:0] outstanding,
    output logic             txn_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ACKED} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               txn_err_q, txn_err_d;
    logic               running, full, empty, push, pop;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (outstanding_q == '0) state_d = flush_req ? ST_ACKED : ST_RUN;
            ST_ACKED: if (!flush_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Outputs; the flush_req gating means no handshake completes while a flush is requested.
    always_comb begin
        running     = (state_q == ST_RUN) && !flush_req;
        full        = (count_q == CNT_W'(DEPTH));
        empty       = (count_q == '0);
        ready_o     = running && !full;
        valid_o     = running && !empty;
        push        = valid_i && ready_o;
        pop         = valid_o && ready_i;
        out         = mem_q[rd_ptr_q];
        issue_allow = running && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        flush_ack   = (state_q == ST_ACKED);
        outstanding = outstanding_q;
        txn_err     = txn_err_q;
    end

    // FIFO bookkeeping; any non-running cycle empties the FIFO and discards its payload.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!running) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    // Outstanding-transaction counter with saturation and sticky error.
    always_comb begin
        outstanding_d = outstanding_q;
        txn_err_d     = txn_err_q;
        if (txn_issue && !txn_done) begin
            if (outstanding_q == OUT_W'(MAX_OUTSTANDING)) txn_err_d = 1'b1;
            else outstanding_d = outstanding_q + OUT_W'(1);
        end else if (txn_done && !txn_issue) begin
            if (outstanding_q == '0) txn_err_d = 1'b1;
            else outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            txn_err_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            txn_err_q     <= txn_err_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk_core) begin
        if (push) mem_q[wr_ptr_q] <= in;
    end

endmodule

// File: tb/tb_hsv_core_flush_responder.sv
// Self-checking bench for hsv_core_flush_responder: a vector table for FIFO/counter behaviour
// plus hand-written flush sequences (ack latency, drain, withdrawal, reset mid-drain).
module tb_hsv_core_flush_responder;

    localparam int WIDTH = 32;
    localparam int OW    = 3;

    logic             clk_core = 1'b0;
    logic             rst_core;
    logic             flush_req, flush_ack;
    logic [WIDTH-1:0] in, out;
    logic             valid_i, ready_o, valid_o, ready_i;
    logic             txn_issue, txn_done, issue_allow, txn_err;
    logic [OW-1:0]    outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    hsv_core_flush_responder #(.WIDTH(WIDTH), .DEPTH(2), .MAX_OUTSTANDING(4)) dut (
        .clk_core   (clk_core),
        .rst_core   (rst_core),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .in         (in),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .out        (out),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .txn_issue  (txn_issue),
        .txn_done   (txn_done),
        .issue_allow(issue_allow),
        .outstanding(outstanding),
        .txn_err    (txn_err)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic          vi;
        logic [31:0]   din;
        logic          ri;
        logic          iss;
        logic          dn;
        logic          e_ro;
        logic          e_vo;
        logic          e_oc;
        logic [31:0]   e_out;
        logic          e_ia;
        logic [OW-1:0] e_os;
        logic          e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check_w(name, 32'(act), 32'(exp));
    endtask

    task automatic check_os(input string name, input logic [OW-1:0] exp);
        check_w(name, 32'(outstanding), 32'(exp));
    endtask

    task automatic idle_inputs();
        flush_req = 1'b0; in = '0; valid_i = 1'b0; ready_i = 1'b0;
        txn_issue = 1'b0; txn_done = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk_core);
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic do_reset();
        rst_core = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_core);
        #1 rst_core = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] os_exp [9];

        // vi, din, ri, iss, dn | ro, vo, out_chk, out, ia, os, err
        vecs.push_back('{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b1, 32'hA5A5_0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0002, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0});
        // simultaneous push and pop keeps occupancy at one
        vecs.push_back('{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b1, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h9ABC_DEF0, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0});
        // counter: issue, issue+done, done, done at zero, sticky error
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b1});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, OW'(k), 1'b1});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 3'd4, 1'b1});
        for (int k = 3; k >= 1; k--)
            vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, OW'(k), 1'b1});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b1});

        os_exp = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};

        // Reset state
        do_reset();
        mid();
        check_b("rst_ready_o", ready_o, 1'b1);
        check_b("rst_valid_o", valid_o, 1'b0);
        check_b("rst_flush_ack", flush_ack, 1'b0);
        check_os("rst_outstanding", 3'd0);
        check_b("rst_txn_err", txn_err, 1'b0);
        check_b("rst_issue_allow", issue_allow, 1'b1);
        step();

        // Vector table
        foreach (vecs[i]) begin
            valid_i = vecs[i].vi; in = vecs[i].din; ready_i = vecs[i].ri;
            txn_issue = vecs[i].iss; txn_done = vecs[i].dn; flush_req = 1'b0;
            mid();
            check_b($sformatf("v%0d_ready_o", i), ready_o, vecs[i].e_ro);
            check_b($sformatf("v%0d_valid_o", i), valid_o, vecs[i].e_vo);
            if (vecs[i].e_oc) check_w($sformatf("v%0d_out", i), out, vecs[i].e_out);
            check_b($sformatf("v%0d_issue_allow", i), issue_allow, vecs[i].e_ia);
            check_os($sformatf("v%0d_outstanding", i), vecs[i].e_os);
            check_b($sformatf("v%0d_txn_err", i), txn_err, vecs[i].e_err);
            check_b($sformatf("v%0d_flush_ack", i), flush_ack, 1'b0);
            step();
        end
        idle_inputs();

        // Flush with two buffered entries: discard, 2-cycle ack, 1-cycle release
        do_reset();
        valid_i = 1'b1; in = 32'hA5A5_0001; step();
        in = 32'hA5A5_0002; step();
        in = 32'hDEAD_BEEF; flush_req = 1'b1;
        mid();
        check_b("fl_c10_ready_o", ready_o, 1'b0);
        check_b("fl_c10_valid_o", valid_o, 1'b0);
        check_b("fl_c10_ack", flush_ack, 1'b0);
        step();
        mid(); check_b("fl_c11_ack", flush_ack, 1'b0); check_b("fl_c11_valid_o", valid_o, 1'b0);
        step();
        mid(); check_b("fl_c12_ack", flush_ack, 1'b1);
        step(); step();
        mid(); check_b("fl_c14_ack", flush_ack, 1'b1);
        step();
        flush_req = 1'b0; valid_i = 1'b0;
        mid(); check_b("fl_c15_ack", flush_ack, 1'b1); check_b("fl_c15_ready_o", ready_o, 1'b0);
        step();
        mid();
        check_b("fl_c16_ack", flush_ack, 1'b0);
        check_b("fl_c16_ready_o", ready_o, 1'b1);
        check_b("fl_c16_valid_o_discarded", valid_o, 1'b0);
        step();

        // Re-assert flush in the first RUN cycle after ACKED
        flush_req = 1'b1; step(); step();
        mid(); check_b("re_acked", flush_ack, 1'b1);
        step();
        flush_req = 1'b0; step();
        flush_req = 1'b1;
        mid(); check_b("re_first_run_ack", flush_ack, 1'b0);
        step();
        mid(); check_b("re_drain_ack", flush_ack, 1'b0);
        step();
        mid(); check_b("re_second_ack", flush_ack, 1'b1);
        step();
        flush_req = 1'b0; step(); step();

        // Flush while three transactions are outstanding; retire at +2, +4, +6
        do_reset();
        txn_issue = 1'b1; repeat (3) step();
        txn_issue = 1'b0; flush_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            txn_done = (k == 2 || k == 4 || k == 6);
            mid();
            check_b($sformatf("dr%0d_ack", k), flush_ack, (k == 8));
            check_b($sformatf("dr%0d_issue_allow", k), issue_allow, 1'b0);
            check_os($sformatf("dr%0d_outstanding", k), os_exp[k]);
            step();
        end
        txn_done = 1'b0; flush_req = 1'b0;
        mid(); check_b("dr_release_ack_held", flush_ack, 1'b1);
        step();
        mid(); check_b("dr_release_ack", flush_ack, 1'b0); check_b("dr_release_allow", issue_allow, 1'b1);
        step();

        // Saturation at MAX_OUTSTANDING sets the error
        txn_issue = 1'b1; repeat (4) step();
        mid(); check_os("sat_at_max", 3'd4); check_b("sat_allow", issue_allow, 1'b0);
        check_b("sat_err_before", txn_err, 1'b0);
        step();
        txn_issue = 1'b0;
        mid(); check_os("sat_held", 3'd4); check_b("sat_err", txn_err, 1'b1);

        // Early withdrawal: drain completes back to RUN without ack
        do_reset();
        txn_issue = 1'b1; step();
        txn_issue = 1'b0; flush_req = 1'b1; step();
        flush_req = 1'b0;
        mid(); check_b("wd_drain_ready_o", ready_o, 1'b0); check_b("wd_drain_ack", flush_ack, 1'b0);
        step();
        txn_done = 1'b1;
        mid(); check_os("wd_os_before_done", 3'd1); check_b("wd_ack_a", flush_ack, 1'b0);
        step();
        txn_done = 1'b0;
        mid(); check_os("wd_os_zero", 3'd0); check_b("wd_still_drain", ready_o, 1'b0);
        check_b("wd_ack_b", flush_ack, 1'b0);
        step();
        mid(); check_b("wd_back_to_run", ready_o, 1'b1); check_b("wd_ack_c", flush_ack, 1'b0);
        check_b("wd_allow", issue_allow, 1'b1);
        step();

        // Asynchronous reset in the middle of a drain
        txn_issue = 1'b1; step();
        txn_issue = 1'b0; flush_req = 1'b1; step();
        flush_req = 1'b0;
        mid(); check_b("rd_in_drain", ready_o, 1'b0); check_os("rd_os_one", 3'd1);
        #2 rst_core = 1'b1;
        #1;
        check_b("rd_ready_o", ready_o, 1'b1);
        check_b("rd_ack", flush_ack, 1'b0);
        check_os("rd_outstanding", 3'd0);
        check_b("rd_allow", issue_allow, 1'b1);
        step();
        rst_core = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
